// File: rtl/npc_pkg.sv
// Shared RV32I decode definitions for the NPC core: opcode constants,
// immediate-form enum, skid-buffer states and the stored decode bundle.
package npc_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_type_e;

  typedef enum logic [1:0] {
    SKID_EMPTY, SKID_ONE, SKID_TWO
  } skid_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  oc;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        illegal;
  } dec_bundle_t;

endpackage

// File: rtl/npc_immgen.sv
// Combinational immediate generator: classifies the opcode, builds the
// sign-extended immediate and flags unsupported encodings.
module npc_immgen
  import npc_pkg::*;
(
  input  logic [31:0] i_inst,
  output imm_type_e   o_imm_type,
  output logic [31:0] o_imm,
  output logic        o_illegal
);

  always_comb begin
    o_imm_type = IMM_NONE;
    o_illegal  = 1'b0;
    if (i_inst[1:0] != 2'b11) begin
      o_illegal = 1'b1;
    end else begin
      case (i_inst[6:0])
        OP_IMM, LOAD, JALR, SYSTEM: o_imm_type = IMM_I;
        STORE:                      o_imm_type = IMM_S;
        BRANCH:                     o_imm_type = IMM_B;
        LUI, AUIPC:                 o_imm_type = IMM_U;
        JAL:                        o_imm_type = IMM_J;
        OP:                         o_imm_type = IMM_NONE;
        default:                    o_illegal  = 1'b1;
      endcase
    end
  end

  always_comb begin
    o_imm = '0;
    case (o_imm_type)
      IMM_I: o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      IMM_S: o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      IMM_B: o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                      i_inst[11:8], 1'b0};
      IMM_U: o_imm = {i_inst[31:12], 12'b0};
      IMM_J: o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                      i_inst[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/npc_idu.sv
// NPC instruction decode stage: decodes fetched words and holds them in a
// two-entry skid buffer so inst_ready depends only on registered state.
module npc_idu
  import npc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] inst_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [6:0]      oc,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  output logic [31:0]     dec_cnt
);

  skid_state_e r_state, w_next;
  dec_bundle_t r_head, r_skid, w_new;
  logic [31:0] r_cnt;
  imm_type_e   w_imm_type;
  logic [31:0] w_imm;
  logic        w_illegal, w_accept, w_consume;

  npc_immgen u_immgen (
    .i_inst     (inst),
    .o_imm_type (w_imm_type),
    .o_imm      (w_imm),
    .o_illegal  (w_illegal)
  );

  always_comb begin
    w_new         = '0;
    w_new.pc      = inst_pc;
    w_new.oc      = inst[6:0];
    w_new.rd      = inst[11:7];
    w_new.funct3  = inst[14:12];
    w_new.rs1     = inst[19:15];
    w_new.rs2     = inst[24:20];
    w_new.funct7  = inst[31:25];
    w_new.imm     = (w_imm_type == IMM_NONE) ? '0 : w_imm;
    w_new.illegal = w_illegal;
  end

  assign w_accept  = inst_valid & inst_ready;
  assign w_consume = dec_valid & dec_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SKID_EMPTY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      SKID_EMPTY: if (w_accept) w_next = SKID_ONE;
      SKID_ONE: begin
        if (w_accept && !w_consume)      w_next = SKID_TWO;
        else if (!w_accept && w_consume) w_next = SKID_EMPTY;
      end
      SKID_TWO: if (w_consume) w_next = SKID_ONE;
      default:  w_next = SKID_EMPTY;
    endcase
  end

  always_comb begin
    inst_ready = (r_state != SKID_TWO) && !rst;
    dec_valid  = (r_state != SKID_EMPTY);
    dec_pc     = r_head.pc;
    oc         = r_head.oc;
    funct3     = r_head.funct3;
    funct7     = r_head.funct7;
    rs1        = r_head.rs1;
    rs2        = r_head.rs2;
    rd         = r_head.rd;
    imm        = r_head.imm;
    illegal    = r_head.illegal;
    dec_cnt    = r_cnt;
  end

  // Head always holds the oldest entry; skid only fills when head is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_skid <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_consume) r_cnt <= r_cnt + 32'd1;
      case (r_state)
        SKID_EMPTY: if (w_accept) r_head <= w_new;
        SKID_ONE: begin
          if (w_accept && w_consume)  r_head <= w_new;
          else if (w_accept)          r_skid <= w_new;
        end
        SKID_TWO: if (w_consume) r_head <= r_skid;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_idu.sv
// Scoreboard bench for npc_idu: directed vectors push hand-computed decodes,
// a negedge monitor pops and compares on every output handshake.
module tb_npc_idu;

  logic        clk = 1'b0, rst = 1'b1;
  logic        inst_valid = 1'b0, dec_ready = 1'b0;
  logic [31:0] inst = '0, inst_pc = '0;
  logic        inst_ready, dec_valid, illegal;
  logic [31:0] dec_pc, imm, dec_cnt;
  logic [6:0]  oc, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;

  npc_idu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .oc(oc), .funct3(funct3), .funct7(funct7), .rs1(rs1),
    .rs2(rs2), .rd(rd), .imm(imm), .illegal(illegal), .dec_cnt(dec_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  oc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t mon_exp, mon_act;
  int   tests = 0, fails = 0, n_sent = 0, last_wait = 0;

  function automatic exp_t mk(logic [31:0] pc, logic [6:0] o, logic [2:0] f3,
                              logic [6:0] f7, logic [4:0] s1, logic [4:0] s2,
                              logic [4:0] d, logic [31:0] im, logic il);
    exp_t e;
    e.pc = pc; e.oc = o; e.f3 = f3; e.f7 = f7; e.rs1 = s1; e.rs2 = s2;
    e.rd = d; e.imm = im; e.ill = il;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] w, input exp_t e);
    bit done = 0;
    inst_valid = 1'b1; inst = w; inst_pc = e.pc; last_wait = 0;
    while (!done) begin
      @(negedge clk);
      if (inst_ready) begin
        q.push_back(e);
        n_sent++;
        done = 1;
      end else if (last_wait >= 20) begin
        tests++; fails++;
        $display("FAIL accept_timeout: inst %h not accepted", w);
        done = 1;
      end else begin
        last_wait++;
      end
      @(posedge clk); #1;
    end
    inst_valid = 1'b0;
  endtask

  task automatic drain(input int exp_cnt);
    int n = 0;
    while (q.size() != 0 && n < 60) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d entries left expected 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
    check("dec_valid_after_drain", {31'b0, dec_valid}, 32'd0);
    check("dec_cnt", dec_cnt, exp_cnt);
  endtask

  always @(negedge clk) begin
    if (!rst && dec_valid && dec_ready) begin
      mon_act = {dec_pc, oc, funct3, funct7, rs1, rs2, rd, imm, illegal};
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got %h expected none", mon_act);
      end else begin
        mon_exp = q.pop_front();
        if (mon_act !== mon_exp) begin
          fails++;
          $display("FAIL decode pc=%h: got %h expected %h", mon_exp.pc, mon_act, mon_exp);
        end
      end
    end
  end

  logic [31:0] vi[10];
  exp_t        ve[10];

  initial begin
    vi[0] = 32'h00500093; ve[0] = mk(32'h100, 7'h13, 3'd0, 7'h00, 5'd0,  5'd5,  5'd1,  32'h00000005, 1'b0);
    vi[1] = 32'hFFF08113; ve[1] = mk(32'h104, 7'h13, 3'd0, 7'h7F, 5'd1,  5'd31, 5'd2,  32'hFFFFFFFF, 1'b0);
    vi[2] = 32'h0020A423; ve[2] = mk(32'h108, 7'h23, 3'd2, 7'h00, 5'd1,  5'd2,  5'd8,  32'h00000008, 1'b0);
    vi[3] = 32'hFE000EE3; ve[3] = mk(32'h10C, 7'h63, 3'd0, 7'h7F, 5'd0,  5'd0,  5'd29, 32'hFFFFFFFC, 1'b0);
    vi[4] = 32'h123452B7; ve[4] = mk(32'h110, 7'h37, 3'd5, 7'h09, 5'd8,  5'd3,  5'd5,  32'h12345000, 1'b0);
    vi[5] = 32'h008000EF; ve[5] = mk(32'h114, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd8,  5'd1,  32'h00000008, 1'b0);
    vi[6] = 32'hFFFFFFFF; ve[6] = mk(32'h118, 7'h7F, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 32'h00000000, 1'b1);
    vi[7] = 32'h00000000; ve[7] = mk(32'h11C, 7'h00, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1);
    vi[8] = 32'h002081B3; ve[8] = mk(32'h120, 7'h33, 3'd0, 7'h00, 5'd1,  5'd2,  5'd3,  32'h00000000, 1'b0);
    vi[9] = 32'hFF812283; ve[9] = mk(32'h124, 7'h03, 3'd2, 7'h7F, 5'd2,  5'd24, 5'd5,  32'hFFFFFFF8, 1'b0);

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    check("rst_inst_ready", {31'b0, inst_ready}, 32'd0);
    check("rst_dec_cnt", dec_cnt, 32'd0);
    check("rst_imm", imm, 32'd0);
    check("rst_dec_pc", dec_pc, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, inst_ready}, 32'd1);
    @(posedge clk); #1;

    // Single transaction and one-cycle latency
    dec_ready = 1'b1;
    send(vi[0], ve[0]);
    check("latency_dec_valid", {31'b0, dec_valid}, 32'd1);
    check("latency_oc", {25'b0, oc}, 32'h13);
    drain(1);

    // Immediate forms, R-type and illegal encodings back-to-back
    for (int k = 1; k < 10; k++) send(vi[k], ve[k]);
    drain(10);

    // Backpressure: two fill the buffer, the third waits
    dec_ready = 1'b0;
    send(32'h00100093, mk(32'h200, 7'h13, 3'd0, 7'h00, 5'd0, 5'd1, 5'd1, 32'd1, 1'b0));
    send(32'h00200113, mk(32'h204, 7'h13, 3'd0, 7'h00, 5'd0, 5'd2, 5'd2, 32'd2, 1'b0));
    check("bp_ready_low", {31'b0, inst_ready}, 32'd0);
    fork
      send(32'h00300193, mk(32'h208, 7'h13, 3'd0, 7'h00, 5'd0, 5'd3, 5'd3, 32'd3, 1'b0));
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_hold_ready", {31'b0, inst_ready}, 32'd0);
          check("bp_hold_pc", dec_pc, 32'h200);
        end
        @(posedge clk); #1 dec_ready = 1'b1;
      end
    join
    drain(13);

    // Streaming at full rate never fills the skid entry
    for (int i = 0; i < 100; i++) begin
      logic [31:0] iv;
      iv = i;
      send((iv << 20) | 32'h13,
           mk(32'h1000 + iv * 4, 7'h13, 3'd0, iv[11:5], 5'd0, iv[4:0], 5'd0, iv, 1'b0));
      check("stream_no_stall", last_wait, 0);
    end
    drain(113);

    // Reset while both entries are held
    dec_ready = 1'b0;
    send(32'h00100093, mk(32'h300, 7'h13, 3'd0, 7'h00, 5'd0, 5'd1, 5'd1, 32'd1, 1'b0));
    send(32'h00200113, mk(32'h304, 7'h13, 3'd0, 7'h00, 5'd0, 5'd2, 5'd2, 32'd2, 1'b0));
    check("two_ready_low", {31'b0, inst_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    check("async_rst_inst_ready", {31'b0, inst_ready}, 32'd0);
    q.delete();
    n_sent = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    check("post_rst_inst_ready", {31'b0, inst_ready}, 32'd1);
    check("post_rst_dec_cnt", dec_cnt, 32'd0);
    @(posedge clk); #1 dec_ready = 1'b1;
    send(vi[4], ve[4]);
    drain(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
